dcache_line: RTL and testbench

One way of the direct-mapped data cache: CACHESIZE words of tag, valid, dirty and byte-banked data storage. It answers CPU read and write requests with hit or miss status. During a controller-driven flush it presents victim data and address for writeback, and accepts refill words from memory. It sits under the dcache controller, which owns the flush sequencing and chooses the victim line from `flush_cnt_miss`.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_line_if.sv | 27 ++
 rtl/dcache_bank.sv | 26 ++
 rtl/dcache_line.sv | 108 ++++++++++
 tb/tb_dcache_line.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, types and address-field helpers for the data cache line.
package dcache_pkg;

    localparam int DATABITS      = 32;
    localparam int ADDRBITS      = 32;
    localparam int CACHEDATABITS = 8;
    localparam int CACHEADDRBITS = 5;
    localparam int LSBITS        = 2;
    localparam int MSBITS        = ADDRBITS - CACHEADDRBITS - LSBITS;
    localparam int BANKNUM       = DATABITS / CACHEDATABITS;
    localparam int CACHESIZE     = 2 ** CACHEADDRBITS;
    localparam int CNTMISSBITS   = 8;

    typedef logic [DATABITS-1:0]      word_t;
    typedef logic [ADDRBITS-1:0]      addr_t;
    typedef logic [CACHEADDRBITS-1:0] idx_t;
    typedef logic [MSBITS-1:0]        tag_t;
    typedef logic [CACHEDATABITS-1:0] byte_t;
    typedef logic [BANKNUM-1:0]       be_t;
    typedef logic [CNTMISSBITS-1:0]   cnt_t;

    function automatic idx_t addr_idx(addr_t a);
        return a[LSBITS+CACHEADDRBITS-1:LSBITS];
    endfunction

    function automatic tag_t addr_tag(addr_t a);
        return a[ADDRBITS-1:LSBITS+CACHEADDRBITS];
    endfunction

endpackage

// File: rtl/dcache_line_if.sv
// CPU-side request/response bundle of one data cache way.
interface dcache_line_if;
    import dcache_pkg::*;

    addr_t dcache_addr;
    word_t dcache_in;
    be_t   byteenable;
    logic  dcache_rdreq;
    logic  dcache_wrreq;
    word_t line_out;
    logic  line_valid;
    logic  line_miss;
    logic  line_dirty;

    modport master (
        output dcache_addr, dcache_in, byteenable,
        output dcache_rdreq, dcache_wrreq,
        input  line_out, line_valid, line_miss, line_dirty
    );

    modport slave (
        input  dcache_addr, dcache_in, byteenable,
        input  dcache_rdreq, dcache_wrreq,
        output line_out, line_valid, line_miss, line_dirty
    );

endinterface

// File: rtl/dcache_bank.sv
// One byte lane of line storage: single write port, registered read port.
module dcache_bank
    import dcache_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  idx_t  addr,
    input  byte_t wdata,
    output byte_t rdata
);

    byte_t mem [CACHESIZE];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Write-first so a write hit returns the merged word next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (we) rdata <= wdata;
        else         rdata <= mem[addr];
    end

endmodule

// File: rtl/dcache_line.sv
// Direct-mapped data cache way: tag/valid/dirty state, miss counter, banks.
module dcache_line
    import dcache_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    dcache_line_if.slave  cpu,
    output cnt_t          flush_cnt_miss,
    input  logic          flush_mode,
    input  logic          flush_write,
    input  idx_t          flush_addr,
    input  logic          flush_dirty,
    output addr_t         mem_addr,
    input  word_t         line_in,
    input  logic          line_in_valid
);

    tag_t                 tag_q [CACHESIZE];
    logic [CACHESIZE-1:0] valid_q;
    logic [CACHESIZE-1:0] dirty_q;

    idx_t  req_idx;
    tag_t  req_tag;
    idx_t  sel_idx;
    logic  hit;
    logic  req;
    logic  wr_hit;
    logic  refill;
    be_t   bank_we;
    word_t bank_wdata;
    word_t bank_rdata;

    always_comb begin
        req_idx = addr_idx(cpu.dcache_addr);
        req_tag = addr_tag(cpu.dcache_addr);
        sel_idx = flush_mode ? flush_addr : req_idx;
        hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        req     = !flush_mode && (cpu.dcache_rdreq || cpu.dcache_wrreq);
        wr_hit  = !flush_mode && cpu.dcache_wrreq && hit;
        refill  = flush_mode && flush_write && line_in_valid;
    end

    always_comb begin
        bank_we    = '0;
        bank_wdata = cpu.dcache_in;
        if (refill) begin
            bank_we    = '1;
            bank_wdata = line_in;
        end else if (wr_hit) begin
            bank_we    = cpu.byteenable;
        end
    end

    for (genvar b = 0; b < BANKNUM; b++) begin : g_bank
        dcache_bank u_bank (
            .clk   (clk),
            .rst_n (reset_n),
            .we    (bank_we[b]),
            .addr  (sel_idx),
            .wdata (bank_wdata[b*CACHEDATABITS +: CACHEDATABITS]),
            .rdata (bank_rdata[b*CACHEDATABITS +: CACHEDATABITS])
        );
    end

    always_ff @(posedge clk) begin
        if (refill) tag_q[flush_addr] <= req_tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill) begin
            valid_q[flush_addr] <= 1'b1;
            dirty_q[flush_addr] <= flush_dirty;
        end else if (wr_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu.line_valid <= 1'b0;
            cpu.line_miss  <= 1'b0;
            cpu.line_dirty <= 1'b0;
            mem_addr       <= '0;
        end else begin
            cpu.line_valid <= req && hit;
            cpu.line_miss  <= req && !hit;
            cpu.line_dirty <= dirty_q[sel_idx];
            mem_addr       <= {tag_q[sel_idx], sel_idx, {LSBITS{1'b0}}};
        end
    end

    // A refill phase restarts the victim statistic for the controller.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt_miss <= '0;
        end else if (flush_mode && flush_write) begin
            flush_cnt_miss <= '0;
        end else if (req && !hit && (flush_cnt_miss != '1)) begin
            flush_cnt_miss <= flush_cnt_miss + 1'b1;
        end
    end

    assign cpu.line_out = bank_rdata;

endmodule

// File: tb/tb_dcache_line.sv
// Randomized self-checking bench for dcache_line against a behavioural model.
module tb_dcache_line;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic flush_mode;
    logic flush_write;
    idx_t flush_addr;
    logic flush_dirty;
    word_t line_in;
    logic line_in_valid;
    addr_t mem_addr;
    cnt_t flush_cnt_miss;

    dcache_line_if bus();

    dcache_line u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu            (bus.slave),
        .flush_cnt_miss (flush_cnt_miss),
        .flush_mode     (flush_mode),
        .flush_write    (flush_write),
        .flush_addr     (flush_addr),
        .flush_dirty    (flush_dirty),
        .mem_addr       (mem_addr),
        .line_in        (line_in),
        .line_in_valid  (line_in_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid [32];
    bit          m_dirty [32];
    int unsigned m_tag   [32];
    logic [31:0] m_data  [32];
    int unsigned m_cnt;

    logic [31:0] e_out;
    logic        e_valid, e_miss, e_dirty;
    logic [31:0] e_maddr;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.dcache_rdreq = 1'b0;
        bus.dcache_wrreq = 1'b0;
        flush_mode       = 1'b0;
        flush_write      = 1'b0;
        line_in_valid    = 1'b0;
        flush_dirty      = 1'b0;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_req(input int unsigned addr, input bit rd,
                             input bit wr, input logic [31:0] din,
                             input logic [3:0] be);
        int unsigned i, t;
        bit hit;
        i = (addr / 4) % 32;
        t = addr / 128;
        hit = m_valid[i] && (m_tag[i] == t);
        e_dirty = m_dirty[i];
        e_maddr = m_tag[i] * 128 + i * 4;
        e_valid = (rd || wr) && hit;
        e_miss  = (rd || wr) && !hit;
        if (e_miss && m_cnt < 255) m_cnt++;
        if (hit && wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_data[i][b*8 +: 8] = din[b*8 +: 8];
            m_dirty[i] = 1;
        end
        e_out = m_data[i];
    endtask

    task automatic drive_req(input logic [31:0] addr, input bit rd,
                             input bit wr, input logic [31:0] din,
                             input logic [3:0] be);
        bus.dcache_addr  = addr;
        bus.dcache_rdreq = rd;
        bus.dcache_wrreq = wr;
        bus.dcache_in    = din;
        bus.byteenable   = be;
        model_req(addr, rd, wr, din, be);
    endtask

    task automatic drive_refill(input int unsigned fa, input logic [31:0] addr,
                                input logic [31:0] data, input bit fd);
        flush_mode      = 1'b1;
        flush_write     = 1'b1;
        line_in_valid   = 1'b1;
        flush_addr      = fa[4:0];
        bus.dcache_addr = addr;
        line_in         = data;
        flush_dirty     = fd;
        m_data[fa]  = data;
        m_tag[fa]   = addr / 128;
        m_valid[fa] = 1;
        m_dirty[fa] = fd;
        m_cnt = 0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle();
        bus.dcache_addr = '0;
        bus.dcache_in   = '0;
        bus.byteenable  = '0;
        flush_addr      = '0;
        line_in         = '0;
        model_reset();
        repeat (3) step();
        n_tests++;
        if ({bus.line_valid, bus.line_miss, bus.line_dirty} !== 3'b000) begin
            $display("FAIL reset_flags got %b want 000",
                     {bus.line_valid, bus.line_miss, bus.line_dirty});
            n_fail++;
        end
        n_tests++;
        if (bus.line_out !== 32'h0 || mem_addr !== 32'h0) begin
            $display("FAIL reset_data got out=%h maddr=%h want 0",
                     bus.line_out, mem_addr);
            n_fail++;
        end
        n_tests++;
        if (flush_cnt_miss !== 8'd0) begin
            $display("FAIL reset_cnt got %0d want 0", flush_cnt_miss);
            n_fail++;
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_first_miss;
        drive_req(32'h80, 1, 0, 32'h0, 4'h0);
        step();
        idle();
        n_tests++;
        if (bus.line_miss !== 1'b1 || bus.line_valid !== 1'b0) begin
            $display("FAIL first_miss got miss=%b valid=%b want 1 0",
                     bus.line_miss, bus.line_valid);
            n_fail++;
        end
        n_tests++;
        if (flush_cnt_miss !== 8'(m_cnt) || m_cnt != 1) begin
            $display("FAIL first_cnt got %0d want 1", flush_cnt_miss);
            n_fail++;
        end
        step();
    endtask

    task automatic test_refill;
        for (int k = 0; k < 32; k++) begin
            drive_refill(k, 32'h80 + 4 * k, 32'h0fff0000 + k, 1'b0);
            step();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            drive_req(32'h80 + 4 * k, 1, 0, 32'h0, 4'h0);
            step();
            n_tests++;
            if (bus.line_valid !== 1'b1 ||
                bus.line_out !== 32'h0fff0000 + k) begin
                $display("FAIL readback%0d got v=%b d=%h want 1 %h", k,
                         bus.line_valid, bus.line_out, 32'h0fff0000 + k);
                n_fail++;
            end
        end
        idle();
        n_tests++;
        if (flush_cnt_miss !== 8'd0) begin
            $display("FAIL refill_cnt got %0d want 0", flush_cnt_miss);
            n_fail++;
        end
        step();
    endtask

    task automatic test_write_writeback;
        drive_req(32'h84, 0, 1, 32'h11223344, 4'b0011);
        step();
        idle();
        n_tests++;
        if (bus.line_valid !== 1'b1 || bus.line_out !== 32'h0fff3344 ||
            e_out !== 32'h0fff3344) begin
            $display("FAIL write_merge got v=%b d=%h want 1 0fff3344",
                     bus.line_valid, bus.line_out);
            n_fail++;
        end
        flush_mode  = 1'b1;
        flush_write = 1'b0;
        flush_addr  = 5'd1;
        step();
        n_tests++;
        if (bus.line_dirty !== 1'b1 || mem_addr !== 32'h84) begin
            $display("FAIL writeback got dirty=%b maddr=%h want 1 84",
                     bus.line_dirty, mem_addr);
            n_fail++;
        end
        n_tests++;
        if (bus.line_out !== m_data[1]) begin
            $display("FAIL wb_data got %h want %h", bus.line_out, m_data[1]);
            n_fail++;
        end
        idle();
        step();
    endtask

    task automatic test_saturate;
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            drive_req(32'h1080, 1, 0, 32'h0, 4'h0);
            step();
            if (bus.line_miss !== 1'b1 || bus.line_valid !== 1'b0) bad++;
        end
        idle();
        n_tests++;
        if (bad != 0) begin
            $display("FAIL conflict_miss got %0d bad cycles want 0", bad);
            n_fail++;
        end
        n_tests++;
        if (flush_cnt_miss !== 8'(m_cnt) || m_cnt != 255) begin
            $display("FAIL saturate got %0d want 255", flush_cnt_miss);
            n_fail++;
        end
        step();
    endtask

    task automatic test_rdwr_both;
        logic [31:0] d;
        d = $urandom;
        drive_req(32'h88, 1, 1, d, 4'hf);
        step();
        idle();
        n_tests++;
        if (bus.line_valid !== 1'b1 || bus.line_out !== d) begin
            $display("FAIL rdwr_both got v=%b d=%h want 1 %h",
                     bus.line_valid, bus.line_out, d);
            n_fail++;
        end
        step();
        n_tests++;
        if (bus.line_valid !== 1'b0 || bus.line_miss !== 1'b0) begin
            $display("FAIL rdwr_pulse got v=%b m=%b want 0 0",
                     bus.line_valid, bus.line_miss);
            n_fail++;
        end
        drive_req(32'h88, 1, 0, 32'h0, 4'h0);
        step();
        idle();
        n_tests++;
        if (bus.line_out !== d || e_out !== d) begin
            $display("FAIL rdwr_read got %h want %h", bus.line_out, d);
            n_fail++;
        end
        step();
    endtask

    task automatic test_random;
        int unsigned op, i, t;
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 5);
            i  = $urandom_range(0, 31);
            t  = $urandom_range(1, 3);
            a  = t * 128 + i * 4;
            if (op == 5) begin
                drive_refill(i, a, $urandom, 1'($urandom));
                bus.dcache_rdreq = 1'($urandom);
                step();
                idle();
                n_tests++;
                if (bus.line_valid !== 1'b0 || bus.line_miss !== 1'b0 ||
                    flush_cnt_miss !== 8'(m_cnt)) begin
                    $display("FAIL rnd_refill%0d got v=%b m=%b c=%0d", n,
                             bus.line_valid, bus.line_miss, flush_cnt_miss);
                    n_fail++;
                end
            end else begin
                drive_req(a, op[0] | (op == 4), op[1], $urandom,
                          4'($urandom));
                step();
                idle();
                n_tests++;
                if (bus.line_valid !== e_valid || bus.line_miss !== e_miss ||
                    flush_cnt_miss !== 8'(m_cnt)) begin
                    $display("FAIL rnd_stat%0d got v=%b m=%b c=%0d want %b %b %0d",
                             n, bus.line_valid, bus.line_miss, flush_cnt_miss,
                             e_valid, e_miss, m_cnt);
                    n_fail++;
                end
                n_tests++;
                if (bus.line_dirty !== e_dirty || mem_addr !== e_maddr) begin
                    $display("FAIL rnd_meta%0d got d=%b a=%h want %b %h", n,
                             bus.line_dirty, mem_addr, e_dirty, e_maddr);
                    n_fail++;
                end
                if (e_valid) begin
                    n_tests++;
                    if (bus.line_out !== e_out) begin
                        $display("FAIL rnd_data%0d got %h want %h", n,
                                 bus.line_out, e_out);
                        n_fail++;
                    end
                end
            end
        end
        step();
    endtask

    task automatic test_reset_mid_refill;
        drive_refill(0, 32'h80, 32'hdeadbeef, 1'b1);
        step();
        drive_refill(1, 32'h84, 32'hcafef00d, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({bus.line_valid, bus.line_miss, bus.line_dirty} !== 3'b000 ||
            bus.line_out !== 32'h0 || mem_addr !== 32'h0 ||
            flush_cnt_miss !== 8'd0) begin
            $display("FAIL mid_reset_outs got v=%b m=%b d=%b o=%h a=%h c=%0d",
                     bus.line_valid, bus.line_miss, bus.line_dirty,
                     bus.line_out, mem_addr, flush_cnt_miss);
            n_fail++;
        end
        step();
        idle();
        reset_n = 1'b1;
        step();
        drive_req(32'h80, 1, 0, 32'h0, 4'h0);
        step();
        idle();
        n_tests++;
        if (bus.line_miss !== 1'b1 || bus.line_valid !== 1'b0 ||
            flush_cnt_miss !== 8'(m_cnt)) begin
            $display("FAIL post_reset got m=%b v=%b c=%0d want 1 0 %0d",
                     bus.line_miss, bus.line_valid, flush_cnt_miss, m_cnt);
            n_fail++;
        end
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_miss();
        test_refill();
        test_write_writeback();
        test_saturate();
        test_rdwr_both();
        test_random();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
